// File: rtl/fb_scanout.sv
// Framebuffer scan-out: generates video timing, fetches packed 2-bit palette
// indices from a double-buffered RAM and swaps buffers only at vblank start.
module fb_scanout #(
  parameter int          H_ACTIVE   = 800,
  parameter int          H_FP       = 40,
  parameter int          H_SYNC     = 48,
  parameter int          H_BP       = 40,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 13,
  parameter int          V_SYNC     = 3,
  parameter int          V_BP       = 29,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int          FB_WORDS   = H_ACTIVE * V_ACTIVE / 16,
  parameter int          ADDR_WIDTH = 16,
  parameter logic [23:0] PALETTE0   = 24'hF7F7F7,
  parameter logic [23:0] PALETTE1   = 24'h535353,
  parameter logic [23:0] PALETTE2   = 24'hDADADA,
  parameter logic [23:0] PALETTE3   = 24'h000000
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  front_buf,
  output logic                  vblank_start,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [23:0]           rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_WIDTH-1:0] FB_BASE = ADDR_WIDTH'(FB_WORDS);
  localparam logic SYNC_IDLE = !SYNC_POL;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic                  front_reg;
  logic                  pending;
  logic                  h_wrap;
  logic                  active;
  logic                  in_hs;
  logic                  in_vs;

  assign h_wrap = (h_cnt == H_LAST);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign in_vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // Swap events are decoded straight from the counters so the painter sees
  // them, and the new front buffer, in the (h=0, v=V_ACTIVE) cycle itself.
  assign vblank_start = !rst && (h_cnt == '0) && (v_cnt == V_ACT);
  assign swap_ack     = vblank_start && (pending || swap_req);
  assign front_buf    = front_reg ^ swap_ack;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // wptr is cleared on the transition into (0,0) so it reads 0 in that cycle.
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      wptr <= '0;
    end else if (h_wrap && (v_cnt == V_LAST)) begin
      wptr <= '0;
    end else if (active && (&h_cnt[3:0])) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      rd_addr <= '0;
    end else begin
      rd_addr <= (front_buf ? FB_BASE : '0) + wptr;
    end
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      front_reg <= 1'b0;
      pending   <= 1'b0;
    end else if (swap_ack) begin
      front_reg <= ~front_reg;
      pending   <= 1'b0;
    end else if (swap_req) begin
      pending <= 1'b1;
    end
  end

  // Three stages carry timing flags and the pixel lane until rd_data arrives.
  logic [3:0] sel_p [3];
  logic       vld_p [3];
  logic       de_p  [3];
  logic       hs_p  [3];
  logic       vs_p  [3];

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      sel_p[0] <= '0;
      vld_p[0] <= 1'b0;
      de_p[0]  <= 1'b0;
      hs_p[0]  <= 1'b0;
      vs_p[0]  <= 1'b0;
    end else begin
      sel_p[0] <= h_cnt[3:0];
      vld_p[0] <= 1'b1;
      de_p[0]  <= active;
      hs_p[0]  <= in_hs;
      vs_p[0]  <= in_vs;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < 3; gi++) begin : g_pipe
      always_ff @(posedge clk_33m) begin
        if (rst) begin
          sel_p[gi] <= '0;
          vld_p[gi] <= 1'b0;
          de_p[gi]  <= 1'b0;
          hs_p[gi]  <= 1'b0;
          vs_p[gi]  <= 1'b0;
        end else begin
          sel_p[gi] <= sel_p[gi-1];
          vld_p[gi] <= vld_p[gi-1];
          de_p[gi]  <= de_p[gi-1];
          hs_p[gi]  <= hs_p[gi-1];
          vs_p[gi]  <= vs_p[gi-1];
        end
      end
    end
  endgenerate

  logic [1:0]  pix_idx;
  logic [23:0] pix_rgb;

  always_comb begin
    pix_idx = rd_data[{sel_p[2], 1'b0} +: 2];
    pix_rgb = PALETTE0;
    case (pix_idx)
      2'd0: pix_rgb = PALETTE0;
      2'd1: pix_rgb = PALETTE1;
      2'd2: pix_rgb = PALETTE2;
      2'd3: pix_rgb = PALETTE3;
      default: pix_rgb = PALETTE0;
    endcase
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      de    <= 1'b0;
      rgb   <= '0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
    end else begin
      de    <= vld_p[2] && de_p[2];
      rgb   <= (vld_p[2] && de_p[2]) ? pix_rgb : '0;
      hsync <= (vld_p[2] && hs_p[2]) ? SYNC_POL : SYNC_IDLE;
      vsync <= (vld_p[2] && vs_p[2]) ? SYNC_POL : SYNC_IDLE;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: full-width lines with a short vertical frame (10 lines)
// so several frames, swaps and resets fit in a short run.
module tb_fb_scanout;

  localparam int HT    = 928;
  localparam int VA    = 4;
  localparam int VT    = 10;
  localparam int FRAME = HT * VT;   // 9280
  localparam int VBK   = HT * VA;   // 3712: vblank offset in a frame
  localparam int FBW   = 200;       // 800*4/16

  logic        clk_33m = 1'b0;
  logic        rst;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic        swap_req;
  logic        swap_ack, front_buf, vblank_start, hsync, vsync, de;
  logic [23:0] rgb;

  always #5 clk_33m = ~clk_33m;

  fb_scanout #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(48), .H_BP(40),
    .V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .FB_WORDS(FBW), .ADDR_WIDTH(16)
  ) dut (
    .clk_33m(clk_33m), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf),
    .vblank_start(vblank_start), .hsync(hsync), .vsync(vsync), .de(de),
    .rgb(rgb)
  );

  // Framebuffer RAM with a fixed 2-cycle read latency.
  logic [31:0] mem [0:511];
  logic [31:0] d1;
  always @(posedge clk_33m) begin
    d1      <= mem[rd_addr[8:0]];
    rd_data <= d1;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic adv_to(input int target);
    while (k < target) begin
      @(negedge clk_33m);
      k++;
      swap_req = 1'b0;
    end
  endtask

  typedef struct {
    int          cyc;
    logic        req;
    logic        de;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic [15:0] addr;
    logic        vb;
    logic        ack;
    logic        fb;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input int c, input logic r, input logic d, input logic [23:0] col,
                     input logic h, input logic v, input int a,
                     input logic vb, input logic ack, input logic fb);
    vec_t e;
    e.cyc = c; e.req = r; e.de = d; e.rgb = col; e.hs = h; e.vs = v;
    e.addr = 16'(a); e.vb = vb; e.ack = ack; e.fb = fb;
    tbl.push_back(e);
  endtask

  int de_cnt, hs_cnt;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[0]   = 32'h000000E4;   // indices 0,1,2,3 then zeros
    mem[FBW] = 32'h0000001B;   // indices 3,2,1,0 in buffer 1

    // Frame 0: reset exit, line-0 unpacking, line timing, swap at vblank.
    add(0,    0, 0, 24'h0,      1, 1, 0,   0, 0, 0);
    add(3,    0, 0, 24'h0,      1, 1, 0,   0, 0, 0);
    add(4,    0, 1, 24'hF7F7F7, 1, 1, 0,   0, 0, 0);
    add(5,    0, 1, 24'h535353, 1, 1, 0,   0, 0, 0);
    add(6,    0, 1, 24'hDADADA, 1, 1, 0,   0, 0, 0);
    add(7,    0, 1, 24'h000000, 1, 1, 0,   0, 0, 0);
    add(8,    0, 1, 24'hF7F7F7, 1, 1, 0,   0, 0, 0);
    add(16,   0, 1, 24'hF7F7F7, 1, 1, 0,   0, 0, 0);
    add(17,   0, 1, 24'hF7F7F7, 1, 1, 1,   0, 0, 0);
    add(19,   0, 1, 24'hF7F7F7, 1, 1, 1,   0, 0, 0);
    add(800,  0, 1, 24'hF7F7F7, 1, 1, 49,  0, 0, 0);
    add(801,  0, 1, 24'hF7F7F7, 1, 1, 50,  0, 0, 0);
    add(803,  0, 1, 24'hF7F7F7, 1, 1, 50,  0, 0, 0);
    add(804,  0, 0, 24'h0,      1, 1, 50,  0, 0, 0);
    add(843,  0, 0, 24'h0,      1, 1, 50,  0, 0, 0);
    add(844,  0, 0, 24'h0,      0, 1, 50,  0, 0, 0);
    add(891,  0, 0, 24'h0,      0, 1, 50,  0, 0, 0);
    add(892,  0, 0, 24'h0,      1, 1, 50,  0, 0, 0);
    add(929,  0, 0, 24'h0,      1, 1, 50,  0, 0, 0);
    add(932,  0, 1, 24'hF7F7F7, 1, 1, 50,  0, 0, 0);
    add(938,  1, 1, 24'hF7F7F7, 1, 1, 50,  0, 0, 0);
    add(3587, 0, 1, 24'hF7F7F7, 1, 1, 200, 0, 0, 0);
    add(3588, 0, 0, 24'h0,      1, 1, 200, 0, 0, 0);
    add(VBK,  0, 0, 24'h0,      1, 1, 200, 1, 1, 1);
    add(VBK+1,0, 0, 24'h0,      1, 1, 400, 0, 0, 1);
    add(5571, 0, 0, 24'h0,      1, 1, 400, 0, 0, 1);
    add(5572, 0, 0, 24'h0,      1, 0, 400, 0, 0, 1);
    add(7427, 0, 0, 24'h0,      1, 0, 400, 0, 0, 1);
    add(7428, 0, 0, 24'h0,      1, 1, 400, 0, 0, 1);
    // Frame 1: swapped base, buffer-1 pixels, vblank without a request.
    add(FRAME,   0, 0, 24'h0,      1, 1, 400, 0, 0, 1);
    add(FRAME+1, 0, 0, 24'h0,      1, 1, 200, 0, 0, 1);
    add(FRAME+4, 0, 1, 24'h000000, 1, 1, 200, 0, 0, 1);
    add(FRAME+5, 0, 1, 24'hDADADA, 1, 1, 200, 0, 0, 1);
    add(FRAME+6, 0, 1, 24'h535353, 1, 1, 200, 0, 0, 1);
    add(FRAME+7, 0, 1, 24'hF7F7F7, 1, 1, 200, 0, 0, 1);
    add(FRAME+VBK,   0, 0, 24'h0,  1, 1, 400, 1, 0, 1);
    add(FRAME+VBK+1, 0, 0, 24'h0,  1, 1, 400, 0, 0, 1);

    rst = 1'b1;
    swap_req = 1'b0;
    repeat (3) begin
      @(negedge clk_33m);
      chk("rst_de", 32'(de), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_sync", {30'd0, hsync, vsync}, 32'd3);
      chk("rst_addr", 32'(rd_addr), 32'd0);
      chk("rst_swap", {29'd0, front_buf, swap_ack, vblank_start}, 32'd0);
    end
    rst = 1'b0;
    k = 0;

    foreach (tbl[i]) begin
      adv_to(tbl[i].cyc);
      swap_req = tbl[i].req;
      #1;
      chk($sformatf("v%0d_de", i),   32'(de),           32'(tbl[i].de));
      chk($sformatf("v%0d_rgb", i),  32'(rgb),          32'(tbl[i].rgb));
      chk($sformatf("v%0d_hs", i),   32'(hsync),        32'(tbl[i].hs));
      chk($sformatf("v%0d_vs", i),   32'(vsync),        32'(tbl[i].vs));
      chk($sformatf("v%0d_addr", i), 32'(rd_addr),      32'(tbl[i].addr));
      chk($sformatf("v%0d_vb", i),   32'(vblank_start), 32'(tbl[i].vb));
      chk($sformatf("v%0d_ack", i),  32'(swap_ack),     32'(tbl[i].ack));
      chk($sformatf("v%0d_fb", i),   32'(front_buf),    32'(tbl[i].fb));
    end

    // Frame 2: one full line window of de and hsync counts.
    adv_to(2*FRAME);
    de_cnt = 0;
    hs_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      #1;
      if (de) de_cnt++;
      if (!hsync) hs_cnt++;
      adv_to(k + 1);
    end
    chk("line_de_count", 32'(de_cnt), 32'd800);
    chk("line_hs_count", 32'(hs_cnt), 32'd48);

    // Request landing on the vblank_start cycle swaps at once (1 -> 0).
    adv_to(2*FRAME + VBK);
    swap_req = 1'b1;
    #1;
    chk("same_cyc_vb", 32'(vblank_start), 32'd1);
    chk("same_cyc_ack", 32'(swap_ack), 32'd1);
    chk("same_cyc_fb", 32'(front_buf), 32'd0);
    adv_to(k + 1);
    #1;
    chk("same_cyc_fb_next", 32'(front_buf), 32'd0);
    chk("same_cyc_addr", 32'(rd_addr), 32'd200);
    adv_to(3*FRAME + VBK);
    #1;
    chk("no_pending_vb", 32'(vblank_start), 32'd1);
    chk("no_pending_ack", 32'(swap_ack), 32'd0);

    // Two requests in one frame give a single swap.
    adv_to(4*FRAME + 1000);
    swap_req = 1'b1;
    adv_to(4*FRAME + 2000);
    swap_req = 1'b1;
    adv_to(4*FRAME + VBK);
    #1;
    chk("dbl_ack", 32'(swap_ack), 32'd1);
    chk("dbl_fb", 32'(front_buf), 32'd1);
    adv_to(5*FRAME + VBK);
    #1;
    chk("dbl_second_ack", 32'(swap_ack), 32'd0);
    chk("dbl_second_fb", 32'(front_buf), 32'd1);

    // Reset mid-line with a swap pending.
    adv_to(6*FRAME + HT + 10);
    swap_req = 1'b1;
    adv_to(6*FRAME + 2*HT + 100);
    rst = 1'b1;
    repeat (2) @(negedge clk_33m);
    #1;
    chk("mid_rst_fb", 32'(front_buf), 32'd0);
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    chk("mid_rst_de", 32'(de), 32'd0);
    rst = 1'b0;
    k = 0;
    adv_to(4);
    #1;
    chk("post_rst_de", 32'(de), 32'd1);
    chk("post_rst_rgb", 32'(rgb), 32'hF7F7F7);
    adv_to(VBK);
    #1;
    chk("post_rst_vb", 32'(vblank_start), 32'd1);
    chk("post_rst_ack", 32'(swap_ack), 32'd0);
    chk("post_rst_fb", 32'(front_buf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Framebuffer reader for the display path, the read-side counterpart of the painter's pixel write stream. It generates 800x480 video timing on `clk_33m`, fetches packed 2-bit palette indices from a double-buffered framebuffer RAM, and emits aligned RGB, sync and data-enable signals. It owns the front/back buffer selection, swapping only at vertical-blank start so that a frame is never displayed half-painted.

## Interface
- `H_ACTIVE`, 800, visible pixels per line; must be a multiple of 16.
- `H_FP`, 40; `H_SYNC`, 48; `H_BP`, 40: horizontal porch and sync lengths. Line total is 928 cycles.
- `V_ACTIVE`, 480; `V_FP`, 13; `V_SYNC`, 3; `V_BP`, 29: vertical timing in lines. Frame total is 525 lines.
- `SYNC_POL`, 0: sync active level; 0 means active-low.
- `FB_WORDS`, H_ACTIVE*V_ACTIVE/16 = 24000: words per buffer. Buffer 1 starts at word `FB_WORDS`.
- `ADDR_WIDTH`, 16: framebuffer word address width.
- `PALETTE0`..`PALETTE3`, 24'hF7F7F7 / 24'h535353 / 24'hDADADA / 24'h000000: RGB888 value for each index.
- `clk_33m` in, 1 bit: pixel clock.
- `rst` in, 1 bit: reset, synchronous, active-high.
- `rd_addr` out, ADDR_WIDTH bits: framebuffer read address, registered.
- `rd_data` in, 32 bits: 16 pixels; pixel i sits in bits [2i+1:2i] (LSB first). Read latency is fixed at 2 cycles.
- `swap_req` in, 1 bit: one-cycle pulse from the painter meaning the back buffer is complete.
- `swap_ack` out, 1 bit: one-cycle pulse when the swap takes effect.
- `front_buf` out, 1 bit: buffer currently displayed. The painter writes to `~front_buf`.
- `vblank_start` out, 1 bit: one-cycle pulse on entry to the first blank line. The painter uses it to start a new frame.
- `hsync`, `vsync`, `de` out, 1 bit each: video timing, aligned with `rgb`.
- `rgb` out, 24 bits: pixel colour; 0 whenever `de` = 0.

## Operation
- Counters:
  - `h_cnt` counts 0..927 and wraps.
  - `v_cnt` increments when `h_cnt` wraps, counts 0..524, and wraps.
  - Active region is h < H_ACTIVE and v < V_ACTIVE.
  - hsync is active for 840 ≤ h < 888.
  - vsync is active for 493 ≤ v < 496.
- Word pointer `wptr`:
  - Cleared at (h=0, v=0).
  - Increments on active cycles where h[3:0] = 15.
  - `rd_addr` is registered as `front_buf`·FB_WORDS + `wptr` and updates every cycle, active or not.
- Pixel select:
  - h[3:0] is delayed to align with `rd_data`.
  - The selected 2-bit index is mapped through PALETTE0..3 into a register.
- Swap mechanism:
  - `swap_req` sets `pending`.
  - At the cycle the counters equal (h=0, v=V_ACTIVE), `vblank_start` pulses.
  - In that same cycle, if `pending` or `swap_req` is high: `front_buf` toggles, `swap_ack` pulses, and `pending` clears.
- `swap_req` while `pending` is already set is absorbed; there is one swap per vblank at most.
- `swap_req` in the same cycle as vblank start swaps immediately and does not leave `pending` set.
- State machine: none beyond the counters. Pipeline stages carry valid bits so that post-reset outputs stay at reset values until real data arrives.

## Timing
- Reset values:
  - h_cnt = v_cnt = 0, `wptr` = 0, `rd_addr` = 0.
  - `front_buf` = 0, `pending` = 0.
  - `swap_ack`, `vblank_start`, `de` = 0; `rgb` = 0.
  - `hsync` = `vsync` = !SYNC_POL (inactive).
  - Pipeline valid bits cleared.
- Reset mid-frame restarts at (0,0) next cycle. A pending swap is discarded and `front_buf` returns to 0.
- Pipeline for the counter state at cycle t:
  - `rd_addr` at t+1.
  - `rd_data` at t+3.
  - `rgb`, `de`, `hsync`, `vsync` registered out at t+4.
- Total pixel latency is 4 cycles; all four video outputs carry the same delay.
- `vblank_start` and `swap_ack` are undelayed and occur in the counter cycle (h=0, v=480). The new `front_buf` is visible in that same cycle.
- The first `rd_addr` of the next frame reflects the swapped base.
- Frame period is 487200 cycles.

## Test plan
- Reset behaviour: hold `rst` 3 cycles, then release. During reset and for 4 cycles after: `de` = 0, `rgb` = 0, `hsync` = `vsync` = 1, `rd_addr` = 0. `de` first rises at cycle 4.
- Pixel unpacking: word 0 = 32'h000000E4, all other words 0. Line 0 `rgb` sequence must be F7F7F7, 535353, DADADA, 000000, then F7F7F7 ×12. `rd_addr` steps 0→1 after h=15 and reaches 49 at h=799.
- Line timing: `hsync` is low for exactly 48 cycles, beginning 844 cycles after the line's first pixel counter. `de` is high for 800 cycles per line and 0 on lines ≥ 480. `vsync` is low for 3 lines from line 493.
- Buffer swap: pulse `swap_req` at line 100. `swap_ack` and `vblank_start` both pulse 445440 cycles after frame start and `front_buf` becomes 1. The next frame's first `rd_addr` is 24000. With no further request, the following vblank produces no `swap_ack`.
- Corner cases:
  - `swap_req` exactly on the vblank_start cycle gives an immediate swap and `pending` = 0.
  - Two `swap_req` pulses in one frame give one swap.
  - `rst` asserted mid-line 200 with `pending` set returns `front_buf` to 0 and gives no `swap_ack` at the next vblank.
